// File: rtl/sddac_mc_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta DAC.
// Dither (SDDAC_MC_DITHER_EN) uses the LFSR constants declared here.
package sddac_mc_pkg;

    localparam int unsigned ORDER_FIRST  = 1;
    localparam int unsigned ORDER_SECOND = 2;

    localparam int unsigned DITHER_W  = 2;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Second-order integrators carry four guard bits above the sample width.
    function automatic int unsigned int_width(input int unsigned w);
        return w + 4;
    endfunction

    // Integrators clip at +/-2^(w+2), i.e. eight times full scale.
    function automatic int unsigned sat_exp(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/sddac_mc_mod.sv
// One-channel sigma-delta modulator: first-order carry accumulator or
// second-order saturating double integrator, selected by ORDER.
module sddac_mc_mod
    import sddac_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ORDER = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [DITHER_W-1:0] dither,
    output logic                    sd_out
);

    if (ORDER == ORDER_FIRST) begin : g_order1
        logic [WIDTH-1:0]        acc;
        logic [WIDTH-1:0]        u_c;
        logic signed [WIDTH+1:0] sum_c;
        logic                    carry_c;

        // Offset-binary input; a negative dithered sum simply yields no carry.
        always_comb begin
            u_c     = {~x[WIDTH-1], x[WIDTH-2:0]};
            sum_c   = $signed({2'b00, acc}) + $signed({2'b00, u_c}) + (WIDTH+2)'(dither);
            carry_c = sum_c[WIDTH] & ~sum_c[WIDTH+1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc    <= '0;
                sd_out <= 1'b0;
            end else begin
                acc    <= sum_c[WIDTH-1:0];
                sd_out <= carry_c;
            end
        end
    end else begin : g_order2
        localparam int unsigned IW = int_width(WIDTH);
        localparam int unsigned SW = IW + 2;
        localparam logic signed [SW-1:0] FS  = SW'(64'sd1 << (WIDTH - 1));
        localparam logic signed [SW-1:0] LIM = SW'(64'sd1 << sat_exp(WIDTH));

        logic signed [IW-1:0] i1;
        logic signed [IW-1:0] i2;
        logic signed [SW-1:0] fb_c;
        logic signed [IW-1:0] i1_nxt_c;
        logic signed [IW-1:0] i2_nxt_c;

        function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
            if (v > LIM) begin
                return IW'(LIM);
            end else if (v < -LIM) begin
                return IW'(-LIM);
            end
            return IW'(v);
        endfunction

        // Both integrators update from the registered state of the previous clock.
        always_comb begin
            fb_c     = sd_out ? FS : -FS;
            i1_nxt_c = sat(SW'(i1) + SW'(x) + SW'(dither) - fb_c);
            i2_nxt_c = sat(SW'(i2) + SW'(i1) - fb_c);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                i1     <= '0;
                i2     <= '0;
                sd_out <= 1'b0;
            end else begin
                i1     <= i1_nxt_c;
                i2     <= i2_nxt_c;
                sd_out <= ~i2_nxt_c[IW-1];
            end
        end
    end

endmodule

// File: rtl/sddac_mc.sv
// Multi-channel sigma-delta audio DAC: frame FIFO, strobe-advanced held frame,
// per-channel PDM modulators. Define SDDAC_MC_DITHER_EN to enable LFSR dither.
module sddac_mc
    import sddac_mc_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned ORDER      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS*WIDTH-1:0]       s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            sample_stb,
    input  logic                            mute,
    input  logic                            underrun_clr,
    output logic [CHANNELS-1:0]             sd_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned FW = CHANNELS * WIDTH;

    if (ORDER != ORDER_FIRST && ORDER != ORDER_SECOND) begin : g_bad_order
        $error("sddac_mc: ORDER must be 1 or 2");
    end

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] held;
    logic          push_c;
    logic          pop_c;
    logic          empty_stb_c;
    logic [LW-1:0] level_nxt_c;

    always_comb begin
        push_c      = s_valid & s_ready;
        pop_c       = sample_stb & (fifo_level != '0);
        empty_stb_c = sample_stb & (fifo_level == '0);
        level_nxt_c = fifo_level;
        if (push_c && !pop_c) begin
            level_nxt_c = fifo_level + LW'(1);
        end else if (pop_c && !push_c) begin
            level_nxt_c = fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_nxt_c;
            s_ready    <= (level_nxt_c != LW'(FIFO_DEPTH));
        end
    end

    // Mute zeroes the held frame but the FIFO head is still consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held     <= '0;
            underrun <= 1'b0;
        end else begin
            if (sample_stb) begin
                if (mute) begin
                    held <= '0;
                end else if (pop_c) begin
                    held <= mem[rd_ptr];
                end
            end
            if (empty_stb_c) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef SDDAC_MC_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ LFSR_POLY;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic signed [DITHER_W-1:0] dith;
`ifdef SDDAC_MC_DITHER_EN
        assign dith = lfsr[(2*n) % LFSR_W +: DITHER_W];
`else
        assign dith = '0;
`endif
        sddac_mc_mod #(
            .WIDTH (WIDTH),
            .ORDER (ORDER)
        ) u_mod (
            .clk    (clk),
            .rst    (rst),
            .x      (held[n*WIDTH +: WIDTH]),
            .dither (dith),
            .sd_out (sd_out[n])
        );
    end

endmodule

// File: tb/tb_sddac_mc.sv
// Scoreboard bench for sddac_mc: an ORDER=1 and an ORDER=2 instance share stimulus;
// expected densities come from (x+FS)/(2FS), FIFO state from a queue model.
module tb_sddac_mc;

    localparam int W     = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int FS    = 32768;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*W-1:0]   s_data;
    logic              s_valid;
    logic              sample_stb;
    logic              mute;
    logic              underrun_clr;
    logic              rdy1, rdy2, und1, und2;
    logic [CH-1:0]     sd1, sd2;
    logic [2:0]        lvl1, lvl2;

    always #5 clk = ~clk;

    sddac_mc #(.WIDTH(W), .CHANNELS(CH), .ORDER(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy1),
        .sample_stb(sample_stb), .mute(mute), .underrun_clr(underrun_clr),
        .sd_out(sd1), .fifo_level(lvl1), .underrun(und1));

    sddac_mc #(.WIDTH(W), .CHANNELS(CH), .ORDER(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy2),
        .sample_stb(sample_stb), .mute(mute), .underrun_clr(underrun_clr),
        .sd_out(sd2), .fifo_level(lvl2), .underrun(und2));

    typedef enum int {K_LEVEL, K_READY, K_UNDER, K_SDZERO, K_DENS} kind_e;
    typedef struct {
        kind_e kind;
        string name;
        int    dut;
        int    exp0;
        int    exp1;
        int    tol;
        int    win;
    } item_t;

    item_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] mq[$];
    logic [31:0] mheld = '0;
    bit          munder = 0;

    task automatic cmp(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Monitor: pops scoreboard items and compares DUT outputs at negedge.
    initial begin
        item_t it;
        int ones0, ones1, cnt;
        ones0 = 0; ones1 = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                it = sb[0];
                case (it.kind)
                    K_LEVEL: begin
                        cmp({it.name, "_lvl1"}, int'(lvl1), it.exp0, 0);
                        cmp({it.name, "_lvl2"}, int'(lvl2), it.exp0, 0);
                        void'(sb.pop_front());
                    end
                    K_READY: begin
                        cmp({it.name, "_rdy1"}, int'(rdy1), it.exp0, 0);
                        cmp({it.name, "_rdy2"}, int'(rdy2), it.exp0, 0);
                        void'(sb.pop_front());
                    end
                    K_UNDER: begin
                        cmp({it.name, "_und1"}, int'(und1), it.exp0, 0);
                        cmp({it.name, "_und2"}, int'(und2), it.exp0, 0);
                        void'(sb.pop_front());
                    end
                    K_SDZERO: begin
                        cmp({it.name, "_sd1"}, int'(sd1), 0, 0);
                        cmp({it.name, "_sd2"}, int'(sd2), 0, 0);
                        void'(sb.pop_front());
                    end
                    default: begin
                        ones0 += (it.dut == 1) ? int'(sd1[0]) : int'(sd2[0]);
                        ones1 += (it.dut == 1) ? int'(sd1[1]) : int'(sd2[1]);
                        cnt++;
                        if (cnt >= it.win) begin
                            cmp({it.name, "_ch0"}, ones0, it.exp0, it.tol);
                            cmp({it.name, "_ch1"}, ones1, it.exp1, it.tol);
                            ones0 = 0; ones1 = 0; cnt = 0;
                            void'(sb.pop_front());
                        end
                    end
                endcase
            end
        end
    end

    function automatic int dens(input logic [15:0] s, input int win);
        int x;
        x = int'($signed(s));
        return ((x + FS) * win + FS) / (2 * FS);
    endfunction

    function automatic logic [15:0] rnd_sample();
        int v;
        v = int'($urandom_range(32'h0, 32'hC000)) - 32'sh6000;
        return 16'(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input string name);
        int b;
        b = 0;
        while (sb.size() != 0 && b < 70000) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d items left, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic add(input kind_e k, input string name, input int dut,
                       input int e0, input int e1, input int tol, input int win);
        item_t it;
        it.kind = k; it.name = name; it.dut = dut;
        it.exp0 = e0; it.exp1 = e1; it.tol = tol; it.win = win;
        sb.push_back(it);
    endtask

    task automatic chk_regs(input string name);
        add(K_LEVEL, name, 0, mq.size(), 0, 0, 1);
        add(K_READY, name, 0, (mq.size() < DEPTH) ? 1 : 0, 0, 0, 1);
        add(K_UNDER, name, 0, int'(munder), 0, 0, 1);
        wait_sb(name);
    endtask

    task automatic chk_dens(input string name, input int dut, input int win, input int tol);
        add(K_DENS, name, dut, dens(mheld[15:0], win), dens(mheld[31:16], win), tol, win);
        wait_sb(name);
    endtask

    task automatic push_frame(input logic [31:0] f);
        s_data  = f;
        s_valid = 1'b1;
        cyc();
        s_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(f);
    endtask

    task automatic strobe(input bit m, input bit clr);
        sample_stb   = 1'b1;
        mute         = m;
        underrun_clr = clr;
        cyc();
        sample_stb   = 1'b0;
        mute         = 1'b0;
        underrun_clr = 1'b0;
        if (mq.size() == 0) begin
            munder = 1;
            if (m) mheld = '0;
        end else begin
            mheld = mq.pop_front();
            if (m) mheld = '0;
            if (clr) munder = 0;
        end
    endtask

    initial begin
        logic [31:0] f;
        rst = 1'b0; s_data = '0; s_valid = 1'b0;
        sample_stb = 1'b0; mute = 1'b0; underrun_clr = 1'b0;
        repeat (3) cyc();
        add(K_SDZERO, "reset", 0, 0, 0, 0, 1);
        chk_regs("reset");
        rst = 1'b1;
        cyc();

        // Zero input: order 2 settles into an exact half-density cycle.
        push_frame(32'h0000_0000);
        strobe(0, 0);
        repeat (8) cyc();
        chk_regs("zero");
        chk_dens("zero_o1", 1, 1024, 1);
        chk_dens("zero_o2", 2, 1024, 0);

        push_frame({16'hC000, 16'h4000});
        strobe(0, 0);
        repeat (8) cyc();
        chk_dens("half_o1", 1, 16384, 17);
        chk_dens("half_o2", 2, 4096, 8);

        push_frame(32'h8000_8000);
        strobe(0, 0);
        repeat (256) cyc();
        chk_dens("negfs_o1", 1, 1024, 1);
        chk_dens("negfs_o2", 2, 1024, 8);

        // Five back-to-back writes into a depth-4 FIFO, then drain.
        for (int i = 0; i < 5; i++) push_frame({rnd_sample(), rnd_sample()});
        chk_regs("full");
        strobe(0, 0);
        repeat (2) cyc();
        chk_regs("pop1");
        for (int i = 0; i < 4; i++) begin
            if (i != 0) strobe(0, 0);
            repeat (64) cyc();
            chk_dens($sformatf("drain%0d_o1", i), 1, 2048, 3);
            chk_dens($sformatf("drain%0d_o2", i), 2, 2048, 8);
        end
        chk_regs("drained");

        // Underrun keeps the last frame; set beats a same-cycle clear.
        push_frame(32'h1234_1234);
        strobe(0, 0);
        strobe(0, 0);
        repeat (8) cyc();
        chk_regs("under");
        chk_dens("under_o1", 1, 2048, 3);
        strobe(0, 1);
        chk_regs("under_setwins");
        underrun_clr = 1'b1;
        cyc();
        underrun_clr = 1'b0;
        munder = 0;
        chk_regs("under_clr");

        f = {rnd_sample(), rnd_sample()};
        push_frame(32'h7FFF_7FFF);
        push_frame(f);
        strobe(1, 0);
        repeat (8) cyc();
        chk_regs("mute");
        chk_dens("mute_o1", 1, 2048, 3);
        strobe(0, 0);
        repeat (64) cyc();
        chk_dens("unmute_o1", 1, 2048, 3);
        chk_dens("unmute_o2", 2, 2048, 8);

        // Asynchronous reset with frames in flight.
        push_frame({rnd_sample(), rnd_sample()});
        push_frame({rnd_sample(), rnd_sample()});
        strobe(0, 0);
        repeat (5) cyc();
        rst = 1'b0;
        mq.delete();
        munder = 0;
        mheld = '0;
        add(K_SDZERO, "midrst", 0, 0, 0, 0, 1);
        chk_regs("midrst");
        cyc();
        rst = 1'b1;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
